// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg : op encodings, sequencer states and counter width for mdu_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_seq_if.sv
// ---------------------------------------------------------------------------
// mdu_seq_if : request/result bundle between an issuer and mdu_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mdu_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

`default_nettype wire

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith : combinational multiply/divide producing {hi,lo}
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic               w_div_zero;
  logic               w_div_ovf;
  logic [31:0]        w_sdiv_b;
  logic [31:0]        w_udiv_b;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;
  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;

  assign w_div_zero = (b == 32'd0);
  assign w_div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Dividing by one in the overflow case yields exactly the required 0x80000000 / 0
  assign w_sdiv_b = (w_div_zero || w_div_ovf) ? 32'd1 : b;
  assign w_udiv_b = w_div_zero ? 32'd1 : b;

  assign w_squot = $signed(a) / $signed(w_sdiv_b);
  assign w_srem  = $signed(a) % $signed(w_sdiv_b);
  assign w_uquot = a / w_udiv_b;
  assign w_urem  = a % w_udiv_b;

  assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_umul = {32'd0, a} * {32'd0, b};

  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = w_smul;
      OP_MULTU: result = w_umul;
      OP_DIV:   result = w_div_zero ? {a, 32'hFFFF_FFFF} : {w_srem, w_squot};
      OP_DIVU:  result = w_div_zero ? {a, 32'hFFFF_FFFF} : {w_urem, w_uquot};
      default:  result = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq : multi-cycle MULT/DIV sequencer with HI/LO result registers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  mdu_seq_if.slave   bus
);

  state_e             r_state;
  state_e             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_n;
  logic [2:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_done;
  logic               w_latch;
  logic               w_commit;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic [63:0]        w_result;

  mdu_arith u_arith (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .result (w_result)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_latch   = 1'b0;
    w_commit  = 1'b0;
    w_wr_hi   = 1'b0;
    w_wr_lo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              w_latch   = 1'b1;
              w_cnt_n   = CNT_W'(MUL_CYCLES);
              w_state_n = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_latch   = 1'b1;
              w_cnt_n   = CNT_W'(DIV_CYCLES);
              w_state_n = S_RUN;
            end
            OP_MTHI: w_wr_hi = 1'b1;
            OP_MTLO: w_wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit  = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_commit;
      if (w_latch) begin
        r_op <= bus.op;
        r_a  <= bus.a;
        r_b  <= bus.b;
      end
      if (w_commit) begin
        {r_hi, r_lo} <= w_result;
      end else begin
        if (w_wr_hi) r_hi <= bus.a;
        if (w_wr_lo) r_lo <= bus.a;
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire
